// File: rtl/rgb2v.sv
// rgb2v: reduces packed RGB pixels to HSV value V = max(R,G,B) and
// buffers them in a small FIFO between a req/ack source and consumer.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   xrst      synchronous active-high reset
//   rgb_in    source pixel {R,G,B}, valid when rcv_ack=1
//   rcv_req   request to source (registered)
//   rcv_ack   source ack, one pixel per cycle it is 1
//   pixel_out V value to consumer, valid when snd_ack=1
//   snd_req   consumer request
//   snd_ack   one-cycle delivery ack (registered)
//   frame_end pulses with the ack of the last pixel of a frame
//   overflow  sticky: pixel arrived while FIFO full
module rgb2v #(
  parameter int DEPTH        = 4,
  parameter int FRAME_PIXELS = 16384
) (
  input  logic        clk,
  input  logic        xrst,
  input  logic [23:0] rgb_in,
  output logic        rcv_req,
  input  logic        rcv_ack,
  output logic [7:0]  pixel_out,
  input  logic        snd_req,
  output logic        snd_ack,
  output logic        frame_end,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FRAME_PIXELS > 2) ?
                      $clog2(FRAME_PIXELS) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] REQ_MAX  = CW'(DEPTH - 2);
  localparam logic [FW-1:0] LAST_PIX = FW'(FRAME_PIXELS - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [FW-1:0] frame_cnt;

  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic [7:0] v;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;

  assign r = rgb_in[23:16];
  assign g = rgb_in[15:8];
  assign b = rgb_in[7:0];

  always_comb begin
    v = r;
    if (g > v) v = g;
    if (b > v) v = b;
  end

  assign full = (count == FULL_CNT);
  assign pop  = snd_req && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO
  // can still accept the incoming pixel.
  assign push = rcv_ack && (!full || pop);
  assign drop = rcv_ack && full && !pop;

  assign count_nx = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (xrst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
      rcv_req   <= 1'b0;
      snd_ack   <= 1'b0;
      pixel_out <= 8'h00;
      frame_end <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      count <= count_nx;
      // Two free slots leaves room for one ack already in flight.
      rcv_req <= (count_nx <= REQ_MAX);
      snd_ack <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        pixel_out <= mem[rd_ptr];
        if (frame_cnt == LAST_PIX) begin
          frame_cnt <= '0;
          frame_end <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
          frame_end <= 1'b0;
        end
      end else begin
        frame_end <= 1'b0;
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !xrst) mem[wr_ptr] <= v;
  end

endmodule

// File: tb/tb_rgb2v.sv
// tb_rgb2v: randomized scoreboard bench for rgb2v with a
// queue-level reference model of the FIFO and frame counter.
module tb_rgb2v;

  localparam int DEPTH = 4;
  localparam int FP    = 8;

  logic        clk = 1'b0;
  logic        xrst = 1'b1;
  logic [23:0] rgb_in = '0;
  logic        rcv_req;
  logic        rcv_ack = 1'b0;
  logic [7:0]  pixel_out;
  logic        snd_req = 1'b0;
  logic        snd_ack;
  logic        frame_end;
  logic        overflow;

  always #5 clk = ~clk;

  rgb2v #(
    .DEPTH(DEPTH),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk),
    .xrst(xrst),
    .rgb_in(rgb_in),
    .rcv_req(rcv_req),
    .rcv_ack(rcv_ack),
    .pixel_out(pixel_out),
    .snd_req(snd_req),
    .snd_ack(snd_ack),
    .frame_end(frame_end),
    .overflow(overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  byte unsigned mq[$];
  byte unsigned exp_q[$];
  bit           live = 0;
  bit           ovf_m = 0;
  bit           req_m = 0;
  bit           ack_m = 0;
  bit           fe_m = 0;
  logic [7:0]   px_m = 0;
  int           fcnt = 0;
  int           pre;
  bit           req_seen = 0;

  function automatic logic [7:0] vmax(logic [23:0] p);
    int r;
    int g;
    int b;
    int m;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    m = r;
    if (g > m) m = g;
    if (b > m) m = b;
    return 8'(m);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %0s t=%0t got=%0h exp=%0h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, evaluated at each edge.
  always @(posedge clk) begin
    live = 1;
    if (xrst) begin
      mq.delete();
      exp_q.delete();
      ovf_m = 0;
      req_m = 0;
      ack_m = 0;
      fe_m  = 0;
      px_m  = 8'h00;
      fcnt  = 0;
    end else begin
      pre   = mq.size();
      ack_m = snd_req && (pre > 0);
      fe_m  = 0;
      if (ack_m) begin
        px_m = mq.pop_front();
        exp_q.push_back(px_m);
        fcnt++;
        if (fcnt == FP) begin
          fe_m = 1;
          fcnt = 0;
        end
      end
      if (rcv_ack) begin
        if (pre < DEPTH || ack_m) mq.push_back(vmax(rgb_in));
        else ovf_m = 1;
      end
      req_m = (mq.size() <= DEPTH - 2);
    end
  end

  // Monitor: pops the scoreboard on every delivery.
  always @(negedge clk) begin
    if (live) begin
      req_seen = rcv_req;
      chk("snd_ack", 32'(snd_ack), 32'(ack_m));
      chk("rcv_req", 32'(rcv_req), 32'(req_m));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("frame_end", 32'(frame_end), 32'(fe_m));
      if (snd_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_ack t=%0t got=%0h exp=none",
                   $time, pixel_out);
        end else begin
          chk("pixel_out", 32'(pixel_out),
              32'(exp_q.pop_front()));
        end
      end else begin
        chk("pixel_hold", 32'(pixel_out), 32'(px_m));
      end
    end
  end

  task automatic drive(input logic a, input logic [23:0] d);
    rcv_ack = a;
    rgb_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 24'h0);
  endtask

  // Source: acks only after a cycle with rcv_req=1.
  task automatic src(input logic [23:0] d);
    for (int k = 0; k < 20; k++) begin
      if (req_seen) begin
        drive(1'b1, d);
        return;
      end
      drive(1'b0, 24'h0);
    end
    n_vec++;
    n_err++;
    $display("FAIL src_timeout t=%0t got=rcv_req_low exp=ack",
             $time);
  endtask

  initial begin
    xrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    xrst = 1'b0;
    idle(2);

    snd_req = 1'b1;
    src(24'h12C840);
    idle(4);
    src(24'h7F7F7F);
    idle(4);
    src(24'h000000);
    idle(4);

    snd_req = 1'b0;
    for (int i = 1; i <= 4; i++) src({8'(i), 16'h0});
    idle(4);
    snd_req = 1'b1;
    src({8'd5, 16'h0});
    idle(8);

    snd_req = 1'b0;
    for (int i = 0; i < 4; i++) src(24'($urandom) & 24'h7F7F7F);
    drive(1'b1, 24'hFF0000);
    idle(3);
    snd_req = 1'b1;
    idle(8);

    snd_req = 1'b0;
    for (int i = 0; i < 3; i++) src(24'($urandom));
    xrst = 1'b1;
    repeat (3) drive(1'b1, 24'($urandom));
    xrst = 1'b0;
    idle(2);
    snd_req = 1'b1;
    idle(6);

    for (int i = 0; i < 117; i++) begin
      if (req_seen) drive(1'b1, 24'($urandom));
      else drive(1'b0, 24'h0);
    end
    idle(6);

    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgb2v.md
# rgb2v

Upstream neighbour of the buffered V-adjust pipeline: receives packed 24-bit RGB pixels from a source over the req/ack receive protocol, reduces each pixel to its HSV value channel V = max(R,G,B), and serves the 8-bit V stream to the pipeline's receive port. A small FIFO decouples source and consumer. A pixel counter marks frame boundaries.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 4.
- FRAME_PIXELS, 16384: pixels per frame; ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- xrst  in  1  reset; synchronous, active-high (1 = reset).
- rgb_in  in  24  source pixel; [23:16]=R, [15:8]=G, [7:0]=B; valid when rcv_ack=1.
- rcv_req  out  1  request to source (this block is MASTER).
- rcv_ack  in  1  source ack; one pixel transferred per cycle it is 1.
- pixel_out  out  8  V value to consumer; valid when snd_ack=1.
- snd_req  in  1  consumer request (this block is SLAVE).
- snd_ack  out  1  one-cycle ack; one pixel delivered per cycle it is 1.
- frame_end  out  1  pulses with the snd_ack of the last pixel of a frame.
- overflow  out  1  sticky error: rcv_ack arrived while FIFO full.

## Operation
- Protocol, both ports: requester holds req level while it wants data; responder drives data and ack=1 for one cycle per transfer; back-to-back acks allowed while req stays 1. The source acks only in a cycle following one in which rcv_req was 1.
- Conversion: on rcv_ack, V = max(R,G,B), unsigned 8-bit compare, ties give the common value. V is written to the FIFO tail in the same cycle. No other arithmetic.
- FIFO: circular buffer of DEPTH×8. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged, including at full and at count=1.
  - Pop of the only entry while pushing a new one is legal.
- Receive flow control: rcv_req is registered. rcv_req(next) = 1 iff count after this cycle's push/pop ≤ DEPTH−2. This gives one cycle of slack for an ack already in flight.
- Overflow: rcv_ack while count=DEPTH and no pop in that cycle:
  - the pixel is dropped;
  - FIFO contents and pointers are unchanged;
  - overflow goes to 1 and stays 1 until reset.
- Send: snd_ack and pixel_out are registered. At a rising edge, if snd_req=1 and count>0 (count before this edge's pop):
  - the head is popped;
  - snd_ack=1 next cycle, with pixel_out = popped value.
  - Otherwise snd_ack=0 and pixel_out holds its previous value.
- Frame counter: counts pops 0..FRAME_PIXELS−1. frame_end=1 exactly in the snd_ack cycle of pop number FRAME_PIXELS−1, after which the counter wraps to 0. Frames are contiguous; no gaps are inserted.
- Reset, including mid-transfer:
  - count, pointers and frame counter go to 0; in-flight and stored pixels are discarded.
  - rcv_req=0, snd_ack=0, pixel_out=0x00, frame_end=0, overflow=0.
  - rcv_req=1 from the first cycle after xrst falls.
  - rcv_ack during reset is ignored.

## Timing
- Throughput: one pixel per cycle sustained when snd_req and source acks stay high.
- Latency: rcv_ack in cycle t (FIFO empty, snd_req=1 at the edge ending t) → snd_ack=1 in cycle t+2 with that pixel's V.
- rcv_req reacts one cycle after the count change. The source may ack at most once more after rcv_req falls.
- frame_end and overflow change only on clock edges; frame_end is never high without snd_ack.
- No combinational path from any input to any output.

## Test plan
- Reset mid-stream: 3 pixels in FIFO, xrst=1 for 3 cycles with rcv_ack=1 → all outputs 0 during reset; after release, rcv_req=1 next cycle, snd_ack stays 0, and no stale pixel ever emerges.
- Single pixel: ack rgb_in=0x12C840 at cycle t with snd_req held 1 → snd_ack=1 only at t+2, pixel_out=0xC8; also 0x7F7F7F → 0x7F and 0x000000 → 0x00.
- Fill with snd_req=0, source acking whenever allowed, inputs R=1,2,3,4,5 (G=B=0):
  - rcv_req falls after the 3rd ack; exactly 4 pixels accepted; overflow=0.
  - Then snd_req=1 → outputs 1,2,3,4 on 4 consecutive snd_ack cycles, and rcv_req returns to 1.
- Forced overflow: FIFO full, snd_req=0, drive rcv_ack=1 with 0xFF0000 → overflow=1 and stays 1; drained data unchanged (no 0xFF).
- Frame wrap with FRAME_PIXELS=8: stream 17 pixels continuously → frame_end high only on deliveries 8 and 16.
- Full-throughput streaming: rcv_ack and snd_req high every cycle, 100 random pixels → output sequence equals max-reduced input in order, one per cycle after 2-cycle latency; count never exceeds 2.
